// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared request-index constants, grant state type and the
//               onehot/index helpers also used by decoder_3to8.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Valid only for a onehot (or zero) input: ORs together the set positions.
   function automatic logic [IDX_W-1:0] onehot2idx(input logic [N_REQ-1:0] oh);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (oh[i]) begin
            r = r | IDX_W'(i);
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/prio_pick8.sv
`default_nettype none
// ============================================================================
// Module      : prio_pick8
// Description : Combinational 8-way picker: highest set bit, or first set bit
//               at/after start (wrapping) when rr=1.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_pick8
   import cpu_pkg::*;
(
   input  logic [N_REQ-1:0] cand,
   input  logic [IDX_W-1:0] start,
   input  logic             rr,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [2*N_REQ-1:0] w_dbl;
   logic [N_REQ-1:0]   w_rot;
   logic [N_REQ-1:0]   w_rev;
   logic [N_REQ-1:0]   w_rr_low;
   logic [N_REQ-1:0]   w_fp_low;

   // Rotating search: rotate so start sits at bit 0, isolate the lowest set
   // bit, then add start back. Fixed priority does the same on a bit-reversal.
   always_comb begin
      w_dbl = {cand, cand};
      w_rot = w_dbl[start +: N_REQ];
      w_rev = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_rev[i] = cand[N_REQ-1-i];
      end
      w_rr_low = w_rot & (~w_rot + N_REQ'(1));
      w_fp_low = w_rev & (~w_rev + N_REQ'(1));
      any      = |cand;
      if (rr) begin
         idx = onehot2idx(w_rr_low) + start;
      end else begin
         idx = IDX_W'(N_REQ-1) - onehot2idx(w_fp_low);
      end
   end

endmodule
`default_nettype wire

// File: rtl/irq_encoder_8to3.sv
`default_nettype none
// ============================================================================
// Module      : irq_encoder_8to3
// Description : Registered 8-to-3 request encoder with pending capture,
//               masking, fixed/rotating priority and valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_encoder_8to3
   import cpu_pkg::*;
#(
   parameter int unsigned ROUND_ROBIN = 0,
   parameter int unsigned EDGE_MODE   = 1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] mask,
   input  logic             encoder_enable,
   output logic [IDX_W-1:0] out,
   output logic             valid,
   input  logic             ack,
   output logic [N_REQ-1:0] pending
);

   state_t           state_q,    state_d;
   logic [N_REQ-1:0] pending_q,  pending_d;
   logic [N_REQ-1:0] req_q;
   logic [IDX_W-1:0] out_q,      out_d;
   logic             valid_q,    valid_d;
   logic [IDX_W-1:0] last_idx_q, last_idx_d;

   logic [N_REQ-1:0] w_set_vec;
   logic [N_REQ-1:0] w_clr_vec;
   logic [N_REQ-1:0] w_cand;
   logic [IDX_W-1:0] w_pick_idx;
   logic             w_pick_any;
   logic [IDX_W-1:0] w_start;

   generate
      if (EDGE_MODE != 0) begin : g_edge_set
         assign w_set_vec = req & ~req_q;
      end else begin : g_level_set
         assign w_set_vec = req;
      end
   endgenerate

   assign w_cand  = pending_q & ~mask;
   assign w_start = last_idx_q + IDX_W'(1);

   prio_pick8 u_pick (
      .cand  (w_cand),
      .start (w_start),
      .rr    (ROUND_ROBIN != 0),
      .idx   (w_pick_idx),
      .any   (w_pick_any)
   );

   always_comb begin
      state_d    = state_q;
      out_d      = out_q;
      valid_d    = valid_q;
      last_idx_d = last_idx_q;
      w_clr_vec  = '0;
      case (state_q)
         IDLE: begin
            if (encoder_enable && w_pick_any) begin
               out_d      = w_pick_idx;
               valid_d    = 1'b1;
               last_idx_d = w_pick_idx;
               state_d    = GRANT;
            end
         end
         GRANT: begin
            if (ack) begin
               w_clr_vec = idx2onehot(out_q);
               valid_d   = 1'b0;
               state_d   = IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
      // Set is ORed after the clear so a fresh edge in the ack cycle re-pends.
      pending_d = (pending_q & ~w_clr_vec) | w_set_vec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         req_q      <= '0;
         out_q      <= '0;
         valid_q    <= 1'b0;
         last_idx_q <= IDX_W'(N_REQ-1);
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         req_q      <= req;
         out_q      <= out_d;
         valid_q    <= valid_d;
         last_idx_q <= last_idx_d;
      end
   end

   assign out     = out_q;
   assign valid   = valid_q;
   assign pending = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_encoder_8to3.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_encoder_8to3
// Description : Self-checking bench: three encoder variants against a
//               behavioural model, plus directed literal scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_irq_encoder_8to3;

   localparam int N_DUT = 3;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req   = 8'h00;
   logic [7:0] mask  = 8'h00;
   logic       en    = 1'b0;
   logic       ack   = 1'b0;
   bit         cmp_en = 1'b0;

   logic [2:0] d_out   [N_DUT];
   logic       d_valid [N_DUT];
   logic [7:0] d_pend  [N_DUT];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   irq_encoder_8to3 #(.ROUND_ROBIN(0), .EDGE_MODE(1)) u_fix (
      .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .encoder_enable(en),
      .out(d_out[0]), .valid(d_valid[0]), .ack(ack), .pending(d_pend[0]));
   irq_encoder_8to3 #(.ROUND_ROBIN(1), .EDGE_MODE(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .encoder_enable(en),
      .out(d_out[1]), .valid(d_valid[1]), .ack(ack), .pending(d_pend[1]));
   irq_encoder_8to3 #(.ROUND_ROBIN(0), .EDGE_MODE(0)) u_lvl (
      .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .encoder_enable(en),
      .out(d_out[2]), .valid(d_valid[2]), .ack(ack), .pending(d_pend[2]));

   function automatic bit rr_of(input int k);
      return (k == 1);
   endfunction

   function automatic bit edge_of(input int k);
      return (k != 2);
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a set of pending request numbers, a busy flag and
   // the number being offered.
   logic [7:0] m_pend [N_DUT];
   logic [7:0] m_prev [N_DUT];
   bit         m_busy [N_DUT];
   int         m_out  [N_DUT];
   int         m_last [N_DUT];

   function automatic int pick(input logic [7:0] cand, input bit rr, input int last);
      if (rr) begin
         for (int off = 1; off <= 8; off++) begin
            if (cand[(last + off) % 8]) return (last + off) % 8;
         end
      end else begin
         for (int i = 7; i >= 0; i--) begin
            if (cand[i]) return i;
         end
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      logic [7:0] setv;
      logic [7:0] clrv;
      int         p;
      if (!rst_n) begin
         for (int k = 0; k < N_DUT; k++) begin
            m_pend[k] = 8'h00; m_prev[k] = 8'h00; m_busy[k] = 1'b0;
            m_out[k]  = 0;     m_last[k] = 7;
         end
      end else begin
         for (int k = 0; k < N_DUT; k++) begin
            setv = edge_of(k) ? (req & ~m_prev[k]) : req;
            clrv = 8'h00;
            if (m_busy[k]) begin
               if (ack) begin
                  clrv[m_out[k]] = 1'b1;
                  m_busy[k] = 1'b0;
               end
            end else begin
               p = pick(m_pend[k] & ~mask, rr_of(k), m_last[k]);
               if (en && p >= 0) begin
                  m_out[k] = p; m_last[k] = p; m_busy[k] = 1'b1;
               end
            end
            m_pend[k] = (m_pend[k] & ~clrv) | setv;
            m_prev[k] = req;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int k = 0; k < N_DUT; k++) begin
            chk($sformatf("cmp_valid%0d", k), 8'(d_valid[k]), 8'(m_busy[k]));
            chk($sformatf("cmp_pend%0d", k), d_pend[k], m_pend[k]);
            if (m_busy[k]) chk($sformatf("cmp_out%0d", k), 8'(d_out[k]), 8'(m_out[k]));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      repeat (2) tick();
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      chk("rst_valid", 8'(d_valid[0]), 8'h00);
      chk("rst_out",   8'(d_out[0]),   8'h00);
      chk("rst_pend",  d_pend[0],      8'h00);
      en = 1'b1;
      tick();

      // Scenario 1: fixed priority, two requests
      req = 8'h24; tick();
      chk("t1_pend", d_pend[0], 8'h24);
      chk("t1_valid0", 8'(d_valid[0]), 8'h00);
      req = 8'h00; tick();
      chk("t1_valid1", 8'(d_valid[0]), 8'h01);
      chk("t1_out5", 8'(d_out[0]), 8'h05);
      ack = 1'b1; tick();
      chk("t1_pend04", d_pend[0], 8'h04);
      chk("t1_gap", 8'(d_valid[0]), 8'h00);
      ack = 1'b0; tick();
      chk("t1_out2", 8'(d_out[0]), 8'h02);
      chk("t1_valid2", 8'(d_valid[0]), 8'h01);
      ack = 1'b1; tick();
      chk("t1_pend0", d_pend[0], 8'h00);
      ack = 1'b0; tick();
      chk("t1_idle", 8'(d_valid[0]), 8'h00);

      // Scenario 2: rotating priority over all eight
      pulse_reset(); tick();
      req = 8'hFF; tick();
      chk("t2_pendFF", d_pend[1], 8'hFF);
      req = 8'h00; tick();
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t2_valid%0d", i), 8'(d_valid[1]), 8'h01);
         chk($sformatf("t2_out%0d", i), 8'(d_out[1]), 8'(i));
         ack = 1'b1; tick();
         chk($sformatf("t2_gap%0d", i), 8'(d_valid[1]), 8'h00);
         ack = 1'b0; tick();
      end
      chk("t2_pend0", d_pend[1], 8'h00);

      // Scenario 3: masked bit waits
      mask = 8'h80; req = 8'h81; tick();
      req = 8'h00; tick();
      chk("t3_out0", 8'(d_out[0]), 8'h00);
      chk("t3_valid", 8'(d_valid[0]), 8'h01);
      ack = 1'b1; tick();
      chk("t3_pend80", d_pend[0], 8'h80);
      ack = 1'b0; tick();
      chk("t3_blocked", 8'(d_valid[0]), 8'h00);
      mask = 8'h00; tick();
      chk("t3_out7", 8'(d_out[0]), 8'h07);
      chk("t3_valid7", 8'(d_valid[0]), 8'h01);
      ack = 1'b1; tick();
      ack = 1'b0;

      // Scenario 4: enable gating
      en = 1'b0; req = 8'h10; tick();
      chk("t4_pend10", d_pend[0], 8'h10);
      req = 8'h00;
      repeat (10) begin
         tick();
         chk("t4_disabled", 8'(d_valid[0]), 8'h00);
      end
      en = 1'b1; tick();
      chk("t4_valid", 8'(d_valid[0]), 8'h01);
      chk("t4_out4", 8'(d_out[0]), 8'h04);
      en = 1'b0;
      repeat (3) begin
         tick();
         chk("t4_hold_v", 8'(d_valid[0]), 8'h01);
         chk("t4_hold_o", 8'(d_out[0]), 8'h04);
      end
      ack = 1'b1; tick();
      chk("t4_acked", 8'(d_valid[0]), 8'h00);
      ack = 1'b0; en = 1'b1; tick();

      // Scenario 5: re-pend in the ack cycle
      req = 8'h08; tick();
      req = 8'h00; tick();
      chk("t5_out3", 8'(d_out[0]), 8'h03);
      req = 8'h08; ack = 1'b1; tick();
      chk("t5_repend", d_pend[0], 8'h08);
      chk("t5_gap", 8'(d_valid[0]), 8'h00);
      req = 8'h00; ack = 1'b0; tick();
      chk("t5_again_v", 8'(d_valid[0]), 8'h01);
      chk("t5_again_o", 8'(d_out[0]), 8'h03);
      ack = 1'b1; tick();
      ack = 1'b0; tick();

      // Scenario 6: asynchronous reset mid-grant
      req = 8'h30; tick();
      req = 8'h00; tick();
      chk("t6_pre_v", 8'(d_valid[0]), 8'h01);
      chk("t6_pre_p", d_pend[0], 8'h30);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_v", 8'(d_valid[0]), 8'h00);
      chk("t6_async_o", 8'(d_out[0]), 8'h00);
      chk("t6_async_p", d_pend[0], 8'h00);
      #1 rst_n = 1'b1;
      repeat (3) begin
         tick();
         chk("t6_quiet", 8'(d_valid[0]), 8'h00);
      end

      // Randomized traffic, including a reset released with requests high
      for (int c = 0; c < 600; c++) begin
         req  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         if ($urandom_range(0, 7) == 0) mask = 8'($urandom);
         en   = ($urandom_range(0, 9) != 0);
         ack  = 1'($urandom_range(0, 1));
         if (c == 300) begin
            req = 8'hFF;
            pulse_reset();
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/irq_encoder_8to3.md
Name: irq_encoder_8to3

Overview:
- Registered 8-to-3 request encoder. It is the inverse of the CPU's 3-to-8 decoder.
- Captures up to eight request lines into a pending register and picks one unmasked pending request by priority.
- Presents the picked request's 3-bit index with a valid/ack handshake, then clears it.
- Sits between peripheral/interrupt sources and the RISC control unit, which acks each index it consumes.

Parameters:
- ROUND_ROBIN, 0, 0 = fixed priority (highest index wins); 1 = rotating priority, search starts at (last granted index + 1) mod 8.
- EDGE_MODE, 1, 1 = a request pends on a rising edge of req; 0 = level (pending is set every cycle req is high).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  8  request lines, synchronous to clk
- mask  input  8  1 = request bit blocked from selection; the bit still pends
- encoder_enable  input  1  1 = selection allowed; 0 = no new grant
- out  output  3  granted index
- valid  output  1  out holds a grant
- ack  input  1  consumer accepts the grant; sampled only while valid=1
- pending  output  8  pending register, for status readout

Behaviour:
Reset (rst_n=0, asynchronous):
- pending=0, req_q=0, out=0, valid=0, last_idx=7 (so round-robin starts its search at 0), state=IDLE.
- Applies immediately, including in the middle of a grant.

Capture:
- Every clock edge, req_q <= req.
- set_vec = req & ~req_q when EDGE_MODE=1; set_vec = req when EDGE_MODE=0.
- pending <= (pending & ~clr_vec) | set_vec.
- If a bit is set and cleared in the same cycle, set wins and the bit stays pending.
- A request held high through reset release counts as a rising edge on the first active edge.

Selection:
- cand = pending & ~mask.
- Fixed priority: highest set bit of cand.
- Rotating priority: first set bit of cand searching upward from last_idx+1, wrapping 7 -> 0.

State machine:
- IDLE:
  - If encoder_enable=1 and cand!=0: out <= selected index, valid <= 1, last_idx <= selected index, go to GRANT.
  - Otherwise stay in IDLE with valid=0.
- GRANT:
  - out and valid are held stable.
  - Changes to mask or encoder_enable have no effect on the current grant; there is no abort.
  - On ack=1 at a clock edge: clr_vec = onehot(out), valid <= 0, go to IDLE.
  - The earliest next grant is on the following edge, so valid is low for at least one cycle between grants.
- ack while in IDLE is ignored.

Latency:
- req rises before edge k -> pending bit set after edge k -> valid=1 after edge k+1 (2 cycles), provided the encoder is idle, enabled and the bit is unmasked.

Boundary conditions:
- All eight requests pending -> grants are issued one at a time; the 8th grant leaves pending=0.
- A masked pending bit is never granted until it is unmasked; it is not lost.
- encoder_enable=0 -> pending still accumulates.
- A new edge on the bit currently being granted, arriving in the ack cycle, re-pends that bit.

Decomposition:
- Shared package (cpu_pkg):
  - constants N_REQ=8 and IDX_W=3
  - state typedef {IDLE, GRANT}
  - onehot-to-index and index-to-onehot functions, shared with decoder_3to8
- One combinational sub-module, prio_pick8:
  - inputs cand[7:0], start[2:0], rr
  - outputs idx[2:0], any

Test Plan:
1. Reset, ROUND_ROBIN=0, EDGE_MODE=1, encoder_enable=1, mask=0; pulse req=8'h24 for one cycle -> pending=8'h24; valid=1 with out=5 two cycles after the pulse; ack -> pending=8'h04, valid=0 for one cycle, then out=2; ack -> pending=0, valid stays 0.
2. ROUND_ROBIN=1; pulse req=8'hFF, ack each grant immediately -> out sequence 0,1,2,3,4,5,6,7, each grant valid for exactly one cycle with one idle cycle between; pending=0 at the end.
3. mask=8'h80, pulse req=8'h81 -> out=0 granted and acked, bit 7 still pending, valid=0; set mask=0 -> out=7 one cycle later.
4. encoder_enable=0 with pending=8'h10 -> valid stays 0 for 10 cycles; set encoder_enable=1 -> valid=1, out=4 after one edge. During that grant set encoder_enable=0 -> out=4 and valid=1 are held until ack.
5. While granting index 3, give a fresh rising edge on req[3] in the same cycle as ack -> pending[3] stays 1 and index 3 is granted again after the one idle cycle.
6. With valid=1 and pending=8'h30, assert rst_n=0 for half a cycle between clock edges -> valid=0, out=0 and pending=0 immediately, without waiting for a clock; no grant follows while req stays 0.
